// File: rtl/elc3_mem_pkg.sv
// Shared types and MMIO constants for the eLC-3 memory responder.
package elc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESPOND  = 2'd2,
    HOLD     = 2'd3
  } state_e;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  localparam int unsigned READY_BIT   = 15;
  localparam int unsigned OVERRUN_BIT = 14;

  function automatic logic [15:0] status_word(input logic ready, input logic overrun);
    logic [15:0] w;
    w              = '0;
    w[READY_BIT]   = ready;
    w[OVERRUN_BIT] = overrun;
    return w;
  endfunction

endpackage

// File: rtl/mem_io_responder_mmio_regs.sv
// Keyboard/display register file for the eLC-3 MMIO window.
// Optional sticky keyboard overrun flag under MEM_IO_KB_OVERRUN_EN.
module mmio_regs
  import elc3_mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rd_i,
  input  logic        wr_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic [15:0] rdata_o,
  input  logic        kb_valid_i,
  input  logic [7:0]  kb_data_i,
  input  logic        dsp_ack_i,
  output logic        dsp_valid_o,
  output logic [7:0]  dsp_data_o
);

  logic       kb_flag_q, kb_flag_d;
  logic [7:0] kb_data_q, kb_data_d;
  logic       dsp_valid_q, dsp_valid_d;
  logic [7:0] dsp_data_q, dsp_data_d;
  logic       ovr_bit;

  // A keystroke in the same cycle as a KBDR read wins: the read sees old data.
  always_comb begin
    kb_flag_d = kb_flag_q;
    kb_data_d = kb_data_q;
    if (rd_i && addr_i == KBDR_ADDR) kb_flag_d = 1'b0;
    if (kb_valid_i) begin
      kb_flag_d = 1'b1;
      kb_data_d = kb_data_i;
    end
  end

  always_comb begin
    dsp_valid_d = dsp_valid_q;
    dsp_data_d  = dsp_data_q;
    if (dsp_valid_q) begin
      if (dsp_ack_i) dsp_valid_d = 1'b0;
    end else if (wr_i && addr_i == DDR_ADDR) begin
      dsp_valid_d = 1'b1;
      dsp_data_d  = wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kb_flag_q   <= 1'b0;
      kb_data_q   <= '0;
      dsp_valid_q <= 1'b0;
      dsp_data_q  <= '0;
    end else begin
      kb_flag_q   <= kb_flag_d;
      kb_data_q   <= kb_data_d;
      dsp_valid_q <= dsp_valid_d;
      dsp_data_q  <= dsp_data_d;
    end
  end

`ifdef MEM_IO_KB_OVERRUN_EN
  logic ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (rd_i && addr_i == KBSR_ADDR) ovr_d = 1'b0;
    if (kb_valid_i && kb_flag_q)     ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovr_q <= 1'b0;
    else         ovr_q <= ovr_d;
  end

  assign ovr_bit = ovr_q;
`else
  assign ovr_bit = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      KBSR_ADDR: rdata_o = status_word(kb_flag_q, ovr_bit);
      KBDR_ADDR: rdata_o = {8'h00, kb_data_q};
      DSR_ADDR:  rdata_o = status_word(~dsp_valid_q, 1'b0);
      default:   rdata_o = '0;
    endcase
  end

  assign dsp_valid_o = dsp_valid_q;
  assign dsp_data_o  = dsp_data_q;

endmodule

// File: rtl/mem_io_responder.sv
// eLC-3 memory-side responder: multi-cycle RAM access or MMIO access, one R pulse per request.
// Optional keyboard overrun status bit under MEM_IO_KB_OVERRUN_EN (see mmio_regs).
module mem_io_responder
  import elc3_mem_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter logic [15:0] MMIO_BASE   = 16'hFE00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] Address,
  input  logic [15:0] Data_In,
  output logic [15:0] Data_Out,
  output logic        R,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ack
);

  localparam logic [3:0] CNT_INIT = 4'(RAM_LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] dout_q;
  logic        r_q;
  logic [15:0] ram_addr_q;
  logic [15:0] ram_wdata_q;
  logic        ram_ce_q;
  logic        ram_we_q;

  logic        accept;
  logic        is_mmio;
  logic        mmio_rd;
  logic        mmio_wr;
  logic [15:0] mmio_rdata;

  assign accept  = (state_q == IDLE) && MIO_EN;
  assign is_mmio = (Address >= MMIO_BASE);
  assign mmio_rd = accept && is_mmio && !R_W;
  assign mmio_wr = accept && is_mmio && R_W;

  mmio_regs u_mmio_regs (
    .clk_i       (Clk),
    .rst_ni      (Reset),
    .rd_i        (mmio_rd),
    .wr_i        (mmio_wr),
    .addr_i      (Address),
    .wdata_i     (Data_In[7:0]),
    .rdata_o     (mmio_rdata),
    .kb_valid_i  (kb_valid),
    .kb_data_i   (kb_data),
    .dsp_ack_i   (dsp_ack),
    .dsp_valid_o (dsp_valid),
    .dsp_data_o  (dsp_data)
  );

  // R is raised on entry to RESPOND, so it is high for exactly the RESPOND cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dout_q      <= '0;
      r_q         <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MIO_EN) begin
            if (!is_mmio) begin
              ram_ce_q    <= 1'b1;
              ram_we_q    <= R_W;
              ram_addr_q  <= Address;
              ram_wdata_q <= Data_In;
              cnt_q       <= CNT_INIT;
              state_q     <= RAM_WAIT;
            end else begin
              if (!R_W) dout_q <= mmio_rdata;
              r_q     <= 1'b1;
              state_q <= RESPOND;
            end
          end
        end
        RAM_WAIT: begin
          if (cnt_q == '0) begin
            if (!ram_we_q) dout_q <= ram_rdata;
            ram_ce_q <= 1'b0;
            ram_we_q <= 1'b0;
            r_q      <= 1'b1;
            state_q  <= RESPOND;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESPOND: begin
          r_q     <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: begin
          if (!MIO_EN) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Data_Out  = dout_q;
  assign R         = r_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;

endmodule
